// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Purpose:
//   This block sits downstream of the 8-bit combinational array multiplier.
//   It takes one 16-bit unsigned product per cycle over a valid/ready
//   handshake. Products are summed into an ACC_W-bit accumulator until a beat
//   arrives with in_last set. The block then presents three values on an
//   output valid/ready handshake:
//     - the frame sum,
//     - the beat count,
//     - a sticky overflow flag.
//   With the multiplier in front, this forms a dot-product / MAC datapath.
//
// Parameters:
//   ACC_W   - accumulator / out_sum width in bits (must be >= 16)
//   COUNT_W - beat counter / out_count width in bits
//
// Ports:
//   clk       in   sole clock; all state updates on the rising edge
//   rst       in   synchronous, active-high reset
//   in_valid  in   in_prod / in_last hold a valid beat
//   in_ready  out  block can accept a beat this cycle
//   in_prod   in   16-bit unsigned product
//   in_last   in   beat closes the current frame
//   out_valid out  out_sum / out_count / out_ovf hold a completed frame
//   out_ready in   consumer takes the result this cycle
//   out_sum   out  frame sum (ACC_W bits)
//   out_count out  beats in the frame (saturating, COUNT_W bits)
//   out_ovf   out  accumulator carried out at least once in the frame
//
// Build option:
//   PRODUCT_ACCUMULATOR_SATURATE_EN
//     Defined:   on carry-out the accumulator clamps to all-ones and stays
//                there for the rest of the frame.
//     Undefined: the accumulator wraps modulo 2^ACC_W.
//     out_ovf is set on carry in both variants.
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int ACC_W   = 20,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf
);

    // Two-state control: ACCUM takes beats, HOLD presents a finished frame.
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic [0:0]         state_q,     state_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [COUNT_W-1:0] count_q,     count_d;
    logic               ovf_q,       ovf_d;
    logic [ACC_W-1:0]   out_sum_q,   out_sum_d;
    logic [COUNT_W-1:0] out_count_q, out_count_d;
    logic               out_ovf_q,   out_ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               release_out;
    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   acc_upd;
    logic [COUNT_W-1:0] count_upd;
    logic               ovf_upd;

    // in_ready is gated by rst so that no beat is offered while reset is held.
    // It rises on the first cycle after rst deasserts.
    assign in_ready    = (state_q == ST_ACCUM) && !rst;
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    // One extra bit on the add exposes the carry out of bit ACC_W-1.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, in_prod};
    assign carry   = sum_ext[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once the accumulator is clamped at all-ones, any non-zero product
    // carries again. A zero product leaves it unchanged. The clamp therefore
    // persists until the frame clears, with no extra state bit.
    assign acc_upd = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_upd = sum_ext[ACC_W-1:0];
`endif

    assign ovf_upd   = ovf_q | carry;
    assign count_upd = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    acc_d   = acc_upd;
                    count_d = count_upd;
                    ovf_d   = ovf_upd;
                    if (in_last) begin
                        // The result registers include the closing beat.
                        out_sum_d   = acc_upd;
                        out_count_d = count_upd;
                        out_ovf_d   = ovf_upd;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (release_out) begin
                    // Frame state clears here, not at the last beat.
                    // The earliest next accept is therefore the cycle after
                    // the handshake, which leaves one bubble per frame.
                    acc_d       = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
